// File: rtl/uart_pkg.sv
// Shared types for the memory-mapped UART transmitter: FSM state encoding
// and the fixed data-bit count of a frame.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO with a combinational head read. A push on full is accepted
// only when a pop frees a slot in the same cycle; otherwise it is flagged on o_drop.
module sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_drop,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_drop    = i_push && !w_do_push;
    assign o_data    = r_mem[r_rd];
    assign o_count   = r_count;

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// UART transmitter snooping processor stores to TX_ADDR; bytes leave 8N1, LSB first.
// Define MMIO_UART_PARITY_EN to insert an even-parity bit between data and stop.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] TX_ADDR      = 32'h0000_00F0,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8,
    localparam int         CW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWrite,
    input  logic [31:0]   Adr,
    input  logic [31:0]   WriteData,
    output logic          txd,
    output logic          busy,
    output logic [CW-1:0] fifo_count,
    output logic          overflow
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(UART_DATA_BITS);

    uart_state_e               r_state;
    logic [BW-1:0]             r_baud;
    logic [IW-1:0]             r_bit;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_par;
    logic                      r_txd;
    logic                      r_ovf;

    logic                      w_push;
    logic                      w_pop;
    logic                      w_empty;
    logic                      w_full;
    logic                      w_drop;
    logic                      w_bit_end;
    logic                      w_last_bit;
    logic [UART_DATA_BITS-1:0] w_head;
    logic                      w_unused;

    assign w_push     = MemWrite && (Adr == TX_ADDR);
    assign w_pop      = (r_state == IDLE) && !w_empty;
    assign w_bit_end  = (r_baud == BW'(CLKS_PER_BIT - 1));
    assign w_last_bit = (r_bit == IW'(UART_DATA_BITS - 1));
    assign w_unused   = ^{WriteData[31:8], w_full};

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_data  (WriteData[UART_DATA_BITS-1:0]),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop),
        .o_count (fifo_count)
    );

    // txd is loaded with the level of the state being entered, so the line
    // changes exactly on the edge that starts each bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_txd   <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            if (w_drop) r_ovf <= 1'b1;
            if (r_state != IDLE) r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
            case (r_state)
                IDLE: begin
                    r_txd <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_par   <= ^w_head;
                        r_baud  <= '0;
                        r_state <= START;
                        r_txd   <= 1'b0;
                    end
                end
                START: if (w_bit_end) begin
                    r_bit   <= '0;
                    r_state <= DATA;
                    r_txd   <= r_shift[0];
                end
                DATA: if (w_bit_end) begin
                    if (w_last_bit) begin
`ifdef MMIO_UART_PARITY_EN
                        r_state <= PARITY;
                        r_txd   <= r_par;
`else
                        r_state <= STOP;
                        r_txd   <= 1'b1;
`endif
                    end else begin
                        r_bit   <= r_bit + 1'b1;
                        r_shift <= r_shift >> 1;
                        r_txd   <= r_shift[1];
                    end
                end
                PARITY: if (w_bit_end) begin
                    r_state <= STOP;
                    r_txd   <= 1'b1;
                end
                STOP: if (w_bit_end) begin
                    r_state <= IDLE;
                    r_txd   <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    assign txd      = r_txd;
    assign overflow = r_ovf;
    assign busy     = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8.
// Build with MMIO_UART_PARITY_EN defined to exercise the parity frame.
module tb_mmio_uart_tx;

    localparam logic [31:0] TX  = 32'h0000_00F0;
    localparam int          CPB = 4;
`ifdef MMIO_UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Adr = '0;
    logic [31:0] WriteData = '0;
    logic        txd;
    logic        busy;
    logic [3:0]  fifo_count;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    mmio_uart_tx #(
        .TX_ADDR      (TX),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .Adr        (Adr),
        .WriteData  (WriteData),
        .txd        (txd),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive the bus at the next falling edge; the following rising edge samples it.
    task automatic bus(input logic we, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemWrite  = we;
        Adr       = a;
        WriteData = d;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (busy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(t < 2000), 1);
    endtask

    // Receiver: find the start bit, then sample each bit near its middle.
    task automatic rx_frame(output logic [7:0] b, output logic p, output logic stp);
        int t = 0;
        b = '0; p = 1'b0; stp = 1'b0;
        while (txd !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("rx_start_seen", 32'(t < 2000), 1);
        if (t >= 2000) return;
        repeat (CPB/2) @(negedge clk);
        chk("rx_start_mid", txd, 0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = txd;
        end
`ifdef MMIO_UART_PARITY_EN
        repeat (CPB) @(negedge clk);
        p = txd;
`endif
        repeat (CPB) @(negedge clk);
        stp = txd;
    endtask

    initial begin
        logic [0:10] pat;
        logic [7:0]  rb;
        logic        rp;
        logic        rs;
        logic [7:0]  exp4 [9];
        int          n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b1;

        // 1. single byte 0xA5: exact line waveform and busy release
`ifdef MMIO_UART_PARITY_EN
        pat = 11'b01010010101;
`else
        pat = {10'b0101001011, 1'b1};
`endif
        bus(1, TX, 32'hA5);
        bus(0, 0, 0);
        chk("t1_txd_store_cycle", txd, 1);
        chk("t1_count", fifo_count, 1);
        for (int k = 0; k < FRAME_BITS*CPB; k++) begin
            @(negedge clk);
            chk($sformatf("t1_txd_c%0d", k), txd, pat[k/CPB]);
        end
        chk("t1_busy_last", busy, 1);
        @(negedge clk);
        chk("t1_busy_done", busy, 0);

        // 2. wrong address, upper-bit alias, and read to TX_ADDR are ignored
        bus(1, 32'h0000_00F4, 32'h55);
        bus(1, 32'h0001_00F0, 32'h55);
        bus(0, TX, 32'h55);
        bus(0, 0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("t2_count", fifo_count, 0);
            chk("t2_txd", txd, 1);
        end
        chk("t2_busy", busy, 0);

        // 3. nine back-to-back stores, all delivered in order
        fork
            begin
                for (int i = 1; i <= 9; i++) begin
                    bus(1, TX, 32'(i));
                    if (i == 3) begin
                        chk("t3_pop_count", fifo_count, 1);
                        chk("t3_pop_txd", txd, 0);
                    end
                end
                bus(0, 0, 0);
                // 0x01 left on the second store's edge, so 0x02..0x09 occupy all 8 slots
                chk("t3_peak_count", fifo_count, 8);
                chk("t3_ovf", overflow, 0);
            end
            begin
                for (int j = 1; j <= 9; j++) begin
                    rx_frame(rb, rp, rs);
                    chk($sformatf("t3_byte%0d", j), rb, 32'(j));
                    chk("t3_stop", rs, 1);
                end
            end
        join
        wait_idle("t3_idle");
        chk("t3_ovf_end", overflow, 0);

        // 4. overfill mid-frame, then a store on full coinciding with a pop
        for (int i = 0; i < 10; i++) bus(1, TX, 32'h10 + 32'(i));
        bus(0, 0, 0);
        chk("t4_count_full", fifo_count, 8);
        chk("t4_ovf_set", overflow, 1);
        if (FRAME_BITS == 10) begin
            repeat (31) @(negedge clk);
            chk("t4_count_before_pop", fifo_count, 8);
            bus(1, TX, 32'h2A);
            bus(0, 0, 0);
            chk("t4_count_push_pop", fifo_count, 8);
            chk("t4_next_start", txd, 0);
        end else begin
            repeat (35) @(negedge clk);
            chk("t4_count_before_pop", fifo_count, 8);
            bus(1, TX, 32'h2A);
            bus(0, 0, 0);
            chk("t4_count_push_pop", fifo_count, 8);
            chk("t4_next_start", txd, 0);
        end
        exp4 = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h2A};
        for (int j = 0; j < 9; j++) begin
            rx_frame(rb, rp, rs);
            chk($sformatf("t4_byte%0d", j), rb, exp4[j]);
        end
        wait_idle("t4_idle");
        chk("t4_ovf_sticky", overflow, 1);

        // 5. reset during DATA bit 3 of 0x35 (bit 3 = 0)
        bus(1, TX, 32'h35);
        bus(1, TX, 32'h36);
        bus(1, TX, 32'h37);
        bus(0, 0, 0);
        repeat (16) @(negedge clk);
        chk("t5_txd_bit3", txd, 0);
        chk("t5_count_pre", fifo_count, 2);
        reset = 1'b0;
        #1;
        chk("t5_rst_txd", txd, 1);
        chk("t5_rst_count", fifo_count, 0);
        chk("t5_rst_ovf", overflow, 0);
        chk("t5_rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        bus(1, TX, 32'h5A);
        bus(0, 0, 0);
        rx_frame(rb, rp, rs);
        chk("t5_byte", rb, 32'h5A);
        chk("t5_stop", rs, 1);
        wait_idle("t5_idle");

        // 6. 0x07: parity bit and total frame length
        bus(1, TX, 32'h07);
        bus(0, 0, 0);
        rx_frame(rb, rp, rs);
        chk("t6_byte", rb, 32'h07);
`ifdef MMIO_UART_PARITY_EN
        chk("t6_parity", rp, 1);
`endif
        chk("t6_stop", rs, 1);
        wait_idle("t6_idle");
        bus(1, TX, 32'h07);
        bus(0, 0, 0);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t6_frame_cycles", 32'(n), 32'(FRAME_CYC));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
